// File: rtl/dual_sram_arbiter.sv
// rtl/dual_sram_arbiter.sv - round-robin two-port arbiter in front of dual_sram
// Optional grant/hazard statistics counters are built when DSA_STATS_EN is defined.
module dual_sram_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_REQ*WIDTH-1:0]      wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [NUM_REQ*WIDTH-1:0]      rdata,
  output logic                          chip_sel,
  output logic                          read_ena_a,
  output logic                          read_ena_b,
  output logic [ADDR_WIDTH-1:0]         address_a,
  output logic [ADDR_WIDTH-1:0]         address_b,
  output logic [WIDTH-1:0]              data_in_a,
  output logic [WIDTH-1:0]              data_in_b,
  input  logic [WIDTH-1:0]              data_out_a,
`ifdef DSA_STATS_EN
  input  logic [WIDTH-1:0]              data_out_b,
  output logic [15:0]                   stat_grants,
  output logic [15:0]                   stat_hazards
`else
  input  logic [WIDTH-1:0]              data_out_b
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [WIDTH-1:0]      wdata_arr [NUM_REQ];
  logic [WIDTH-1:0]      rdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign addr_arr[g]           = addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g]          = wdata[g*WIDTH +: WIDTH];
    assign rdata[g*WIDTH +: WIDTH] = rdata_arr[g];
  end

  logic [PTR_W-1:0] rr_ptr, rr_next, last_idx;
  logic [PTR_W:0]   scan_sum;
  logic [PTR_W-1:0] scan_idx;
  logic             a_found, b_found, hazard_skip;
  logic [PTR_W-1:0] a_idx, b_idx;
  logic             rd_valid_a, rd_valid_b;
  logic [PTR_W-1:0] rd_id_a, rd_id_b;
  logic             a_win, b_win;

  // Scan from rr_ptr; the second winner must not hazard with port A's access.
  always_comb begin
    a_found     = 1'b0;
    b_found     = 1'b0;
    hazard_skip = 1'b0;
    a_idx       = '0;
    b_idx       = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
      if (scan_sum >= NUM_REQ_W) scan_sum = scan_sum - NUM_REQ_W;
      scan_idx = scan_sum[PTR_W-1:0];
      if (req[scan_idx]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_idx   = scan_idx;
        end else if (!b_found) begin
          if ((addr_arr[scan_idx] == addr_arr[a_idx]) && (we[scan_idx] || we[a_idx])) begin
            hazard_skip = 1'b1;
          end else begin
            b_found = 1'b1;
            b_idx   = scan_idx;
          end
        end
      end
    end
  end

  assign a_win    = a_found & ~reset;
  assign b_win    = b_found & ~reset;
  assign last_idx = b_found ? b_idx : a_idx;
  assign rr_next  = (last_idx == LAST_IDX) ? '0 : last_idx + 1'b1;

  always_comb begin
    gnt = '0;
    if (a_win) gnt[a_idx] = 1'b1;
    if (b_win) gnt[b_idx] = 1'b1;
  end

  // An idle port beside an active one reads address 0 so it can never write.
  always_comb begin
    chip_sel   = a_win;
    read_ena_a = 1'b0;
    read_ena_b = 1'b0;
    address_a  = '0;
    address_b  = '0;
    data_in_a  = '0;
    data_in_b  = '0;
    if (a_win) begin
      read_ena_a = ~we[a_idx];
      address_a  = addr_arr[a_idx];
      data_in_a  = we[a_idx] ? wdata_arr[a_idx] : '0;
      read_ena_b = 1'b1;
      if (b_win) begin
        read_ena_b = ~we[b_idx];
        address_b  = addr_arr[b_idx];
        data_in_b  = we[b_idx] ? wdata_arr[b_idx] : '0;
      end
    end
  end

  always_comb begin
    rvalid = '0;
    for (int i = 0; i < NUM_REQ; i++) rdata_arr[i] = '0;
    if (!reset && rd_valid_a) begin
      rvalid[rd_id_a]    = 1'b1;
      rdata_arr[rd_id_a] = data_out_a;
    end
    if (!reset && rd_valid_b) begin
      rvalid[rd_id_b]    = 1'b1;
      rdata_arr[rd_id_b] = data_out_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= '0;
      rd_valid_a <= 1'b0;
      rd_valid_b <= 1'b0;
      rd_id_a    <= '0;
      rd_id_b    <= '0;
    end else begin
      if (a_found) rr_ptr <= rr_next;
      rd_valid_a <= a_found & ~we[a_idx];
      rd_id_a    <= a_idx;
      rd_valid_b <= b_found & ~we[b_idx];
      rd_id_b    <= b_idx;
    end
  end

`ifdef DSA_STATS_EN
  logic [16:0] grant_sum;
  logic [16:0] hazard_sum;

  assign grant_sum  = {1'b0, stat_grants} + 17'(a_found) + 17'(b_found);
  assign hazard_sum = {1'b0, stat_hazards} + 17'(hazard_skip);

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_grants  <= '0;
      stat_hazards <= '0;
    end else begin
      stat_grants  <= grant_sum[16]  ? 16'hFFFF : grant_sum[15:0];
      stat_hazards <= hazard_sum[16] ? 16'hFFFF : hazard_sum[15:0];
    end
  end
`endif

endmodule
